// File: rtl/led_animator_pkg.sv
// Shared encodings and LED pattern constants for the board LED animator.
package led_animator_pkg;

  localparam int LED_W = 10;
  typedef logic [LED_W-1:0] ledVec_t;

  localparam logic [2:0] MODE_FUEL   = 3'b000;
  localparam logic [2:0] MODE_CHASE  = 3'b001;
  localparam logic [2:0] MODE_BOUNCE = 3'b010;
  localparam logic [2:0] MODE_BLINK  = 3'b011;
  localparam logic [2:0] MODE_OFF    = 3'b100;
  localparam logic [2:0] MODE_ALLON  = 3'b101;

  localparam ledVec_t PAT_PB_A = 10'b0101010101;
  localparam ledVec_t PAT_PB_B = 10'b1010101010;
  localparam ledVec_t LED_ALL  = 10'h3FF;

  typedef enum logic [1:0] {CELEB_IDLE, CELEB_PB, CELEB_GB} celebState_t;

  function automatic ledVec_t rotl1(input ledVec_t v);
    return {v[LED_W-2:0], v[LED_W-1]};
  endfunction

endpackage

// File: rtl/anim_tick_gen.sv
// Animation prescaler: one-cycle tick on the wrap cycle of a 0..ANIM_DIV-1 counter.
// Latency: tick is combinational from the counter; a clear restarts the count and masks that cycle's tick.
module anim_tick_gen #(
  parameter int ANIM_DIV = 2_500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap = (cnt == CW'(ANIM_DIV - 1));
  assign tick = wrap & ~clear;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (clear || wrap) cnt <= '0;
    else                    cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/led_animator.sv
// Board LED driver: mode patterns plus a timed best-score celebration overlay.
// Latency 1 clk (registered output); no backpressure, the LEDs consume every cycle.
module led_animator
  import led_animator_pkg::*;
#(
  parameter int ANIM_DIV    = 2_500_000,
  parameter int CELEB_STEPS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] FuelGaugeIn,
  input  logic [2:0] DispMode,
  input  logic       NewPersonalBest,
  input  logic       NewGlobalBest,
  output logic [9:0] LEDDispOut
);

  localparam int SW = $clog2(CELEB_STEPS + 1);

  logic [2:0]    modeQ;
  ledVec_t       posQ, posD;
  logic          dirLeftQ, dirLeftD;
  logic          phaseQ, phaseD;
  celebState_t   stateQ, stateD;
  logic [SW-1:0] stepQ, stepD;
  ledVec_t       ledD;
  logic          tick, modeChange, celebStart;

  assign modeChange = (DispMode != modeQ);
  // A personal best cannot interrupt a running global celebration.
  assign celebStart = NewGlobalBest | (NewPersonalBest & (stateQ != CELEB_GB));

  anim_tick_gen #(.ANIM_DIV(ANIM_DIV)) uTick (
    .clk  (clk),
    .rst  (rst),
    .clear(modeChange | celebStart),
    .tick (tick)
  );

  always_comb begin
    stateD = stateQ;
    stepD  = stepQ;
    if (NewGlobalBest) begin
      stateD = CELEB_GB;
      stepD  = '0;
    end else if (celebStart) begin
      stateD = CELEB_PB;
      stepD  = '0;
    end else if (stateQ != CELEB_IDLE && tick) begin
      if (stepQ == SW'(CELEB_STEPS - 1)) begin
        stateD = CELEB_IDLE;
        stepD  = '0;
      end else begin
        stepD = stepQ + SW'(1);
      end
    end
  end

  always_comb begin
    posD     = posQ;
    dirLeftD = dirLeftQ;
    phaseD   = phaseQ;
    if (modeChange) begin
      posD     = ledVec_t'(1);
      dirLeftD = 1'b1;
      phaseD   = 1'b0;
    end else begin
      if (celebStart) phaseD = 1'b0;
      else if (tick)  phaseD = ~phaseQ;
      if (tick) begin
        case (DispMode)
          MODE_CHASE: posD = rotl1(posQ);
          MODE_BOUNCE: begin
            if (dirLeftQ) begin
              if (posQ[LED_W-1]) begin
                dirLeftD = 1'b0;
                posD     = posQ >> 1;
              end else begin
                posD = posQ << 1;
              end
            end else begin
              if (posQ[0]) begin
                dirLeftD = 1'b1;
                posD     = posQ << 1;
              end else begin
                posD = posQ >> 1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Output is built from next-state values so it lands exactly one clk after the inputs.
  always_comb begin
    ledD = '0;
    case (stateD)
      CELEB_PB: ledD = phaseD ? PAT_PB_B : PAT_PB_A;
      CELEB_GB: ledD = phaseD ? '0 : LED_ALL;
      default: begin
        case (DispMode)
          MODE_FUEL:   ledD = FuelGaugeIn;
          MODE_CHASE:  ledD = posD;
          MODE_BOUNCE: ledD = posD;
          MODE_BLINK:  ledD = phaseD ? '0 : FuelGaugeIn;
          MODE_ALLON:  ledD = LED_ALL;
          default:     ledD = '0;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      modeQ      <= MODE_FUEL;
      posQ       <= ledVec_t'(1);
      dirLeftQ   <= 1'b1;
      phaseQ     <= 1'b0;
      stateQ     <= CELEB_IDLE;
      stepQ      <= '0;
      LEDDispOut <= '0;
    end else begin
      modeQ      <= DispMode;
      posQ       <= posD;
      dirLeftQ   <= dirLeftD;
      phaseQ     <= phaseD;
      stateQ     <= stateD;
      stepQ      <= stepD;
      LEDDispOut <= ledD;
    end
  end

endmodule

// File: tb/tb_led_animator.sv
// Table-driven bench for led_animator with a queue scoreboard; ANIM_DIV=4, CELEB_STEPS=4.
module tb_led_animator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] FuelGaugeIn = '0;
  logic [2:0] DispMode = '0;
  logic       NewPersonalBest = 1'b0;
  logic       NewGlobalBest = 1'b0;
  logic [9:0] LEDDispOut;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] fuel;
    logic [2:0] mode;
    logic       pb;
    logic       gb;
    int         n;
    logic [9:0] exp;
    string      name;
  } vec_t;

  vec_t       vecs[$];
  logic [9:0] expQ[$];

  localparam logic [9:0] F    = 10'b1110000000;
  localparam logic [9:0] PA   = 10'b0101010101;
  localparam logic [9:0] PB   = 10'b1010101010;
  localparam logic [9:0] ALL  = 10'h3FF;
  localparam logic [9:0] NONE = 10'h000;

  led_animator #(.ANIM_DIV(4), .CELEB_STEPS(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .FuelGaugeIn    (FuelGaugeIn),
    .DispMode       (DispMode),
    .NewPersonalBest(NewPersonalBest),
    .NewGlobalBest  (NewGlobalBest),
    .LEDDispOut     (LEDDispOut)
  );

  always #5 clk = ~clk;

  function automatic void addV(input logic [9:0] fuel, input logic [2:0] mode, input logic pb,
                               input logic gb, input int n, input logic [9:0] exp, input string name);
    vec_t v;
    v.fuel = fuel; v.mode = mode; v.pb = pb; v.gb = gb; v.n = n; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endfunction

  task automatic checkOut(input string name);
    logic [9:0] e;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %b", name, LEDDispOut);
    end else begin
      e = expQ.pop_front();
      if (LEDDispOut !== e) begin
        errors++;
        $display("FAIL %s: got %b expected %b at %0t", name, LEDDispOut, e, $time);
      end
    end
  endtask

  task automatic runVec(input vec_t v);
    FuelGaugeIn     = v.fuel;
    DispMode        = v.mode;
    NewPersonalBest = v.pb;
    NewGlobalBest   = v.gb;
    for (int c = 0; c < v.n; c++) begin
      expQ.push_back(v.exp);
      @(posedge clk);
      #1;
      checkOut(v.name);
    end
  endtask

  initial begin
    logic [9:0] one;
    one = 10'd1;

    addV(F, 3'd0, 0, 0, 2, F, "fuel_after_reset");
    addV(10'b0000011111, 3'd0, 0, 0, 1, 10'b0000011111, "fuel_passthru");
    addV(F, 3'd0, 0, 0, 1, F, "fuel_back");
    // personal celebration from a one-cycle pulse
    addV(F, 3'd0, 1, 0, 1, PA, "pb_start");
    addV(F, 3'd0, 0, 0, 3, PA, "pb_ph0");
    addV(F, 3'd0, 0, 0, 4, PB, "pb_ph1");
    addV(F, 3'd0, 0, 0, 4, PA, "pb_ph0b");
    addV(F, 3'd0, 0, 0, 4, PB, "pb_ph1b");
    addV(F, 3'd0, 0, 0, 4, F, "pb_end");
    // global overrides personal mid-celebration
    addV(F, 3'd0, 1, 0, 1, PA, "pb2_start");
    addV(F, 3'd0, 0, 0, 2, PA, "pb2_run");
    addV(F, 3'd0, 0, 1, 1, ALL, "gb_over_pb");
    addV(F, 3'd0, 0, 0, 3, ALL, "gb_ph0");
    addV(F, 3'd0, 0, 0, 4, NONE, "gb_ph1");
    addV(F, 3'd0, 0, 0, 4, ALL, "gb_ph0b");
    addV(F, 3'd0, 0, 0, 4, NONE, "gb_ph1b");
    addV(F, 3'd0, 0, 0, 4, F, "gb_end");
    // personal during global is ignored
    addV(F, 3'd0, 0, 1, 1, ALL, "gb2_start");
    addV(F, 3'd0, 0, 0, 2, ALL, "gb2_run");
    addV(F, 3'd0, 1, 0, 1, ALL, "pb_ignored");
    addV(F, 3'd0, 0, 0, 4, NONE, "gb2_ph1");
    addV(F, 3'd0, 0, 0, 4, ALL, "gb2_ph0");
    addV(F, 3'd0, 0, 0, 4, NONE, "gb2_ph1b");
    addV(F, 3'd0, 0, 0, 4, F, "gb2_end");
    // both high, then held high keeps restarting
    addV(F, 3'd0, 1, 1, 1, ALL, "both_gb");
    addV(F, 3'd0, 1, 1, 6, ALL, "held_restart");
    addV(F, 3'd0, 0, 0, 3, ALL, "held_rel");
    addV(F, 3'd0, 0, 0, 4, NONE, "held_ph1");
    addV(F, 3'd0, 0, 0, 4, ALL, "held_ph0");
    addV(F, 3'd0, 0, 0, 4, NONE, "held_ph1b");
    addV(F, 3'd0, 0, 0, 4, F, "held_end");
    // mode change during celebration is hidden until it ends
    addV(F, 3'd0, 1, 0, 1, PA, "pb3_start");
    addV(F, 3'd5, 0, 0, 4, PA, "pb3_modechg");
    addV(F, 3'd5, 0, 0, 4, PB, "pb3_ph1");
    addV(F, 3'd5, 0, 0, 4, PA, "pb3_ph0");
    addV(F, 3'd5, 0, 0, 4, PB, "pb3_ph1b");
    addV(F, 3'd5, 0, 0, 4, ALL, "pb3_end_allon");
    for (int i = 0; i < 10; i++) addV(F, 3'd1, 0, 0, 4, one << i, "chase");
    addV(F, 3'd1, 0, 0, 4, one, "chase_wrap");
    for (int i = 0; i < 10; i++) addV(F, 3'd2, 0, 0, 4, one << i, "bounce_up");
    for (int i = 8; i >= 0; i--) addV(F, 3'd2, 0, 0, 4, one << i, "bounce_down");
    addV(F, 3'd2, 0, 0, 4, one << 1, "bounce_rev0");
    addV(F, 3'd3, 0, 0, 4, F, "blink_on");
    addV(F, 3'd3, 0, 0, 4, NONE, "blink_off");
    addV(F, 3'd3, 0, 0, 4, F, "blink_on2");
    addV(F, 3'd4, 0, 0, 2, NONE, "mode_off");
    addV(F, 3'd6, 0, 0, 2, NONE, "mode_110");
    addV(F, 3'd7, 0, 0, 2, NONE, "mode_111");
    addV(F, 3'd5, 0, 0, 2, ALL, "mode_allon");
    addV(F, 3'd0, 0, 0, 1, F, "mode_fuel");

    FuelGaugeIn = F;
    #2 rst = 1'b1;
    #1;
    expQ.push_back(NONE);
    checkOut("reset_immediate");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[k]) runVec(vecs[k]);

    // async reset in the middle of a celebration
    runVec('{F, 3'd0, 1'b1, 1'b0, 1, PA, "rst_pb_start"});
    runVec('{F, 3'd0, 1'b0, 1'b0, 2, PA, "rst_pb_run"});
    #2 rst = 1'b1;
    #1;
    expQ.push_back(NONE);
    checkOut("rst_mid_celeb");
    @(posedge clk);
    #1;
    expQ.push_back(NONE);
    checkOut("rst_held");
    rst = 1'b0;
    runVec('{F, 3'd0, 1'b0, 1'b0, 8, F, "after_rst_no_celeb"});

    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
